// File: rtl/facto_core_q.sv
// Purpose : memory-mapped factorial engine; operands queue in, {ovf,n!} results queue out, one multiply per cycle.
// Latency : result visible max(n,1) edges after the operand pop edge; back-to-back jobs have one IDLE cycle between them.
// Backpressure: operand push into a full queue is dropped (sticky drop flag); the core stalls in IDLE while the result queue is full.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   s_sel      slave select
//   s_wr       1 = write, 0 = read (qualified by s_sel)
//   s_addr     byte address, only [7:0] decoded
//   s_din      write data
//   s_dout     combinational read data, 0 unless a read is selected
//   interrupt  level interrupt built only from registered flags
module facto_core_q #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);

    localparam int RES_W = 2 * DATA_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ENT_W = RES_W + 1;   // {ovf, result}

    localparam logic [7:0] A_OPSTART = 8'h00;
    localparam logic [7:0] A_OPCLEAR = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h10;
    localparam logic [7:0] A_INTREN  = 8'h18;
    localparam logic [7:0] A_OPERAND = 8'h20;
    localparam logic [7:0] A_RES_H   = 8'h28;
    localparam logic [7:0] A_RES_L   = 8'h30;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0] w_addr;
    logic       w_bus_rd;
    logic       w_bus_wr;
    logic       w_clr;
    logic       w_op_push_req;
    logic       w_res_pop_req;
    logic       w_unused;

    assign w_addr        = s_addr[7:0];
    assign w_bus_rd      = s_sel & ~s_wr;
    assign w_bus_wr      = s_sel & s_wr;
    assign w_clr         = w_bus_wr & (w_addr == A_OPCLEAR) & s_din[0];
    assign w_op_push_req = w_bus_wr & (w_addr == A_OPERAND);
    assign w_res_pop_req = w_bus_rd & (w_addr == A_RES_L);
    assign w_unused      = ^s_addr[15:8];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_opstart;
    logic [1:0]        r_intren;
    logic              r_drop;
    logic [RES_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_k;
    logic              r_ovf;

    logic [DATA_W-1:0] r_op_mem [DEPTH];
    logic [AW-1:0]     r_op_wr;
    logic [AW-1:0]     r_op_rd;
    logic [CW-1:0]     r_op_cnt;

    logic [ENT_W-1:0]  r_res_mem [DEPTH];
    logic [AW-1:0]     r_res_wr;
    logic [AW-1:0]     r_res_rd;
    logic [CW-1:0]     r_res_cnt;

    // ------------------------------------------------------------------
    // Queue status
    // ------------------------------------------------------------------
    logic              w_op_full;
    logic              w_op_empty;
    logic              w_res_full;
    logic              w_res_empty;
    logic [DATA_W-1:0] w_op_head;
    logic [ENT_W-1:0]  w_res_head;

    assign w_op_full   = (r_op_cnt == CW'(DEPTH));
    assign w_op_empty  = (r_op_cnt == '0);
    assign w_res_full  = (r_res_cnt == CW'(DEPTH));
    assign w_res_empty = (r_res_cnt == '0);
    assign w_op_head   = r_op_mem[r_op_rd];
    assign w_res_head  = r_res_mem[r_res_rd];

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    logic w_go;
    logic w_k_last;
    logic w_job_start;
    logic w_job_done;
    logic w_op_push;
    logic w_res_pop;
    logic w_drop_set;

    // A job may only start when its result is guaranteed a slot.
    assign w_go       = r_opstart & ~w_op_empty & ~w_res_full;
    assign w_k_last   = (r_k[DATA_W-1:1] == '0);   // k <= 1
    // Full is sampled before any same-edge core pop, so a push into a
    // full queue is lost even if the core frees a slot on that edge.
    assign w_op_push  = w_op_push_req & ~w_op_full & ~w_clr;
    assign w_drop_set = w_op_push_req & w_op_full;
    assign w_res_pop  = w_res_pop_req & ~w_res_empty & ~w_clr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_clr && w_go) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_clr || w_k_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs (clear overrides both the pop and the push)
    always_comb begin
        w_job_start = 1'b0;
        w_job_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_job_start = w_go & ~w_clr;
            S_MUL:   w_job_done  = w_k_last & ~w_clr;
            default: begin
                w_job_start = 1'b0;
                w_job_done  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: acc *= k while k counts down to 1
    // ------------------------------------------------------------------
    logic [RES_W+DATA_W-1:0] w_prod;

    assign w_prod = {{DATA_W{1'b0}}, r_acc} * {{RES_W{1'b0}}, r_k};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_k   <= '0;
            r_ovf <= 1'b0;
        end else if (w_job_start) begin
            r_acc <= RES_W'(1);
            r_k   <= w_op_head;
            r_ovf <= 1'b0;
        end else if (r_state == S_MUL && !w_k_last) begin
            r_acc <= w_prod[RES_W-1:0];
            r_ovf <= r_ovf | (|w_prod[RES_W+DATA_W-1:RES_W]);
            r_k   <= r_k - DATA_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Operand queue: bus pushes, core pops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_wr  <= '0;
            r_op_rd  <= '0;
            r_op_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op_mem[i] <= '0;
            end
        end else if (w_clr) begin
            r_op_wr  <= '0;
            r_op_rd  <= '0;
            r_op_cnt <= '0;
        end else begin
            if (w_op_push) begin
                r_op_mem[r_op_wr] <= s_din;
                r_op_wr           <= r_op_wr + AW'(1);
            end
            if (w_job_start) begin
                r_op_rd <= r_op_rd + AW'(1);
            end
            case ({w_op_push, w_job_start})
                2'b10:   r_op_cnt <= r_op_cnt + CW'(1);
                2'b01:   r_op_cnt <= r_op_cnt - CW'(1);
                default: r_op_cnt <= r_op_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result queue: core pushes, RESULT_L read pops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_res_mem[i] <= '0;
            end
        end else if (w_clr) begin
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_job_done) begin
                r_res_mem[r_res_wr] <= {r_ovf, r_acc};
                r_res_wr            <= r_res_wr + AW'(1);
            end
            if (w_res_pop) begin
                r_res_rd <= r_res_rd + AW'(1);
            end
            case ({w_job_done, w_res_pop})
                2'b10:   r_res_cnt <= r_res_cnt + CW'(1);
                2'b01:   r_res_cnt <= r_res_cnt - CW'(1);
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opstart <= 1'b0;
            r_intren  <= 2'b00;
            r_drop    <= 1'b0;
        end else begin
            if (w_clr) begin
                r_opstart <= 1'b0;
                r_drop    <= 1'b0;
            end else begin
                if (w_bus_wr && w_addr == A_OPSTART) begin
                    r_opstart <= s_din[0];
                end
                if (w_drop_set) begin
                    r_drop <= 1'b1;
                end
            end
            if (w_bus_wr && w_addr == A_INTREN) begin
                r_intren <= s_din[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_status;

    always_comb begin
        w_status        = '0;
        w_status[0]     = ~w_res_empty;
        w_status[1]     = (r_state != S_IDLE);
        w_status[2]     = w_op_full;
        w_status[3]     = w_op_empty;
        w_status[4]     = ~w_res_empty & w_res_head[RES_W];
        w_status[5]     = r_drop;
        w_status[15:8]  = 8'(r_res_cnt);
        w_status[23:16] = 8'(r_op_cnt);
    end

    always_comb begin
        s_dout = '0;
        if (w_bus_rd) begin
            case (w_addr)
                A_OPSTART: s_dout[0]   = r_opstart;
                A_STATUS:  s_dout      = w_status;
                A_INTREN:  s_dout[1:0] = r_intren;
                A_RES_H:   s_dout      = w_res_empty ? '0 : w_res_head[RES_W-1:DATA_W];
                A_RES_L:   s_dout      = w_res_empty ? '0 : w_res_head[DATA_W-1:0];
                default:   s_dout      = '0;
            endcase
        end
    end

    assign interrupt = (r_intren[0] & ~w_res_empty) | (r_intren[1] & r_drop);

endmodule

// File: tb/tb_facto_core_q.sv
module tb_facto_core_q;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    localparam logic [7:0] A_OPSTART = 8'h00;
    localparam logic [7:0] A_OPCLEAR = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h10;
    localparam logic [7:0] A_INTREN  = 8'h18;
    localparam logic [7:0] A_OPERAND = 8'h20;
    localparam logic [7:0] A_RES_H   = 8'h28;
    localparam logic [7:0] A_RES_L   = 8'h30;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              s_sel;
    logic              s_wr;
    logic [15:0]       s_addr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s_dout;
    logic              interrupt;

    always #5 clk = ~clk;

    facto_core_q #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    typedef struct packed {
        logic         ovf;
        logic [127:0] val;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    // n! reduced mod 2^128; 34! < 2^128 < 35!, so truncation begins at n = 35.
    function automatic res_t fact(input int n);
        res_t r;
        r.val = 128'd1;
        for (int i = 2; i <= n; i++) begin
            r.val = r.val * 128'(i);
        end
        r.ovf = (n >= 35);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Combinational read inside the current cycle; never spans a clock edge.
    task automatic peek(input logic [7:0] a, output logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = {8'h00, a};
        #1;
        d      = s_dout;
        s_sel  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = {8'h00, a};
        s_din  = d;
        @(posedge clk);
        #1;
        s_sel  = 1'b0;
        s_wr   = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(output int cyc);
        logic [63:0] st;
        cyc = 0;
        peek(A_STATUS, st);
        while (!st[0] && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            peek(A_STATUS, st);
        end
        chk("done_seen", 128'(st[0]), 128'(1));
    endtask

    // Read head via STATUS/RESULT_H, then pop it with a RESULT_L read.
    task automatic pop_chk(input string tag);
        logic [63:0] st;
        logic [63:0] hi;
        logic [63:0] lo;
        res_t        e;
        e = exp_q.pop_front();
        peek(A_STATUS, st);
        peek(A_RES_H, hi);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = {8'h00, A_RES_L};
        #1;
        lo = s_dout;
        @(posedge clk);
        #1;
        s_sel = 1'b0;
        chk({tag, "_ovf"}, 128'(st[4]), 128'(e.ovf));
        chk({tag, "_val"}, {hi, lo}, e.val);
    endtask

    task automatic drain(input string tag);
        int cyc;
        while (exp_q.size() > 0) begin
            wait_done(cyc);
            pop_chk(tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] st;
        logic [63:0] rv;
        int          cyc;
        int          n;
        int          k;

        reset_n = 1'b0;
        s_sel   = 1'b0;
        s_wr    = 1'b0;
        s_addr  = '0;
        s_din   = '0;

        // Reset state
        #1;
        chk("rst_dout", 128'(s_dout), 128'(0));
        chk("rst_int", 128'(interrupt), 128'(0));
        peek(A_STATUS, st);
        chk("rst_status", 128'(st), 128'h08);
        @(negedge clk);
        reset_n = 1'b1;
        edges(1);

        // 1: 5! with interrupt on done
        wr(A_INTREN, 64'd1);
        wr(A_OPERAND, 64'd5);
        exp_q.push_back(fact(5));
        wr(A_OPSTART, 64'd1);
        peek(A_STATUS, st);
        chk("t1_busy_pre", 128'(st[1]), 128'(0));
        chk("t1_opcnt_pre", 128'(st[23:16]), 128'(1));
        edges(1);
        peek(A_STATUS, st);
        chk("t1_busy", 128'(st[1]), 128'(1));
        chk("t1_opcnt", 128'(st[23:16]), 128'(0));
        wait_done(cyc);
        chk("t1_latency", 128'(cyc), 128'(5));
        chk("t1_int_on", 128'(interrupt), 128'(1));
        pop_chk("t1");
        chk("t1_int_off", 128'(interrupt), 128'(0));
        peek(A_STATUS, st);
        chk("t1_status_after", 128'(st), 128'h08);

        // 2: 0! and 1!, one edge each after pop
        wr(A_OPERAND, 64'd0);
        exp_q.push_back(fact(0));
        wait_done(cyc);
        chk("t2_latency0", 128'(cyc), 128'(2));
        wr(A_OPERAND, 64'd1);
        exp_q.push_back(fact(1));
        peek(A_STATUS, st);
        chk("t2_rcnt_a", 128'(st[15:8]), 128'(1));
        edges(1);
        peek(A_STATUS, st);
        chk("t2_rcnt_b", 128'(st[15:8]), 128'(1));
        edges(1);
        peek(A_STATUS, st);
        chk("t2_rcnt_c", 128'(st[15:8]), 128'(2));
        pop_chk("t2a");
        pop_chk("t2b");
        peek(A_STATUS, st);
        chk("t2_rcnt_end", 128'(st[15:8]), 128'(0));

        // 3: fill operand queue while stopped, overflow drops
        wr(A_OPSTART, 64'd0);
        for (int i = 3; i <= 6; i++) begin
            wr(A_OPERAND, 64'(i));
            exp_q.push_back(fact(i));
        end
        peek(A_STATUS, st);
        chk("t3_full", 128'(st[2]), 128'(1));
        chk("t3_opcnt", 128'(st[23:16]), 128'(4));
        chk("t3_nodrop", 128'(st[5]), 128'(0));
        wr(A_OPERAND, 64'd7);
        peek(A_STATUS, st);
        chk("t3_drop", 128'(st[5]), 128'(1));
        chk("t3_opcnt_drop", 128'(st[23:16]), 128'(4));
        wr(A_OPSTART, 64'd1);
        drain("t3");
        wr(A_INTREN, 64'd2);
        chk("t3_int_drop", 128'(interrupt), 128'(1));
        wr(A_INTREN, 64'd1);
        chk("t3_int_masked", 128'(interrupt), 128'(0));

        // 4: overflow boundary
        wr(A_OPERAND, 64'd35);
        exp_q.push_back(fact(35));
        drain("t4_35");
        wr(A_OPERAND, 64'd34);
        exp_q.push_back(fact(34));
        drain("t4_34");

        // 5: result queue full stalls the core
        wr(A_OPSTART, 64'd0);
        for (int i = 2; i <= 5; i++) begin
            wr(A_OPERAND, 64'(i));
            exp_q.push_back(fact(i));
        end
        wr(A_OPSTART, 64'd1);
        cyc = 0;
        peek(A_STATUS, st);
        while (st[15:8] != 8'd4 && cyc < 200) begin
            edges(1);
            cyc++;
            peek(A_STATUS, st);
        end
        chk("t5_rfull", 128'(st[15:8]), 128'(4));
        wr(A_OPERAND, 64'd7);
        exp_q.push_back(fact(7));
        wr(A_OPERAND, 64'd2);
        exp_q.push_back(fact(2));
        edges(10);
        peek(A_STATUS, st);
        chk("t5_idle", 128'(st[1]), 128'(0));
        chk("t5_opcnt", 128'(st[23:16]), 128'(2));
        chk("t5_rcnt", 128'(st[15:8]), 128'(4));
        pop_chk("t5_first");
        peek(A_STATUS, st);
        chk("t5_idle_pop_edge", 128'(st[1]), 128'(0));
        edges(1);
        peek(A_STATUS, st);
        chk("t5_started", 128'(st[1]), 128'(1));
        chk("t5_opcnt_after", 128'(st[23:16]), 128'(1));
        drain("t5");

        // Randomized batches against the model
        for (int b = 0; b < 4; b++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                n = $urandom_range(0, 40);
                wr(A_OPERAND, 64'(n));
                exp_q.push_back(fact(n));
            end
            drain("rnd");
        end

        // 6: clear mid-multiply flushes everything
        wr(A_OPERAND, 64'd2);
        wr(A_OPERAND, 64'd20);
        edges(6);
        wr(A_OPERAND, 64'd3);
        peek(A_STATUS, st);
        chk("t6_pre_done", 128'(st[0]), 128'(1));
        chk("t6_pre_busy", 128'(st[1]), 128'(1));
        chk("t6_pre_opcnt", 128'(st[23:16]), 128'(1));
        wr(A_OPCLEAR, 64'd1);
        peek(A_STATUS, st);
        chk("t6_clr_status", 128'(st), 128'h08);
        peek(A_OPSTART, rv);
        chk("t6_clr_opstart", 128'(rv), 128'(0));
        edges(40);
        peek(A_STATUS, st);
        chk("t6_no_result", 128'(st), 128'h08);

        // Async reset mid-operation
        wr(A_INTREN, 64'd3);
        wr(A_OPSTART, 64'd1);
        wr(A_OPERAND, 64'd1);
        wr(A_OPERAND, 64'd10);
        edges(4);
        peek(A_STATUS, st);
        chk("t6_busy_pre_rst", 128'(st[1]), 128'(1));
        chk("t6_int_pre_rst", 128'(interrupt), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("t6_int_rst", 128'(interrupt), 128'(0));
        peek(A_STATUS, st);
        chk("t6_status_rst", 128'(st), 128'h08);
        peek(A_OPSTART, rv);
        chk("t6_opstart_rst", 128'(rv), 128'(0));
        peek(A_INTREN, rv);
        chk("t6_intren_rst", 128'(rv), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        edges(15);
        peek(A_STATUS, st);
        chk("t6_status_post", 128'(st), 128'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
